// File: rtl/fir_output_requant.sv
// -----------------------------------------------------------------------------
// fir_output_requant
//
// Output requantization stage behind the FIR datapath. Each accepted wide
// accumulator sample is rounded (round-half-up), arithmetically right-shifted
// by a per-job shift amount, saturated to OUT_WIDTH and presented on a
// registered valid/ready source. A beat counter frames each job of len_i
// samples. done_o pulses for one cycle when the job is complete.
//
// Optional feature: define FIR_REQUANT_SAT_CNT_EN to add the 16-bit saturating
// sat_cnt_o counter of saturated beats. It is cleared on reset, clear_i and
// start.
//
// Ports
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   clear_i        : synchronous soft clear, same effect as reset
//   start_i        : job start pulse, honoured only in IDLE
//   len_i          : samples in the job, latched on start
//   shift_i        : right-shift amount, latched on start
//   y_*            : accumulator sink stream (valid/ready/data/strb; strb ignored)
//   z_*            : requantized source stream (strb all-ones)
//   sat_cnt_o      : saturation event count (FIR_REQUANT_SAT_CNT_EN only)
//   busy_o         : high while a job is in RUN or DONE
//   done_o         : one-cycle pulse at job end
// -----------------------------------------------------------------------------
module fir_output_requant #(
    parameter int unsigned IN_WIDTH    = 32,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned SHIFT_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [15:0]            len_i,
    input  logic [SHIFT_WIDTH-1:0] shift_i,
    input  logic                   y_valid_i,
    output logic                   y_ready_o,
    input  logic [IN_WIDTH-1:0]    y_data_i,
    input  logic [IN_WIDTH/8-1:0]  y_strb_i,
    output logic                   z_valid_o,
    input  logic                   z_ready_i,
    output logic [OUT_WIDTH-1:0]   z_data_o,
    output logic [OUT_WIDTH/8-1:0] z_strb_o,
`ifdef FIR_REQUANT_SAT_CNT_EN
    output logic [15:0]            sat_cnt_o,
`endif
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Clamp bounds and rounding constant, all in the IN_WIDTH+1 working width.
    localparam logic signed [IN_WIDTH:0] SAT_MAX =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] SAT_MIN =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [IN_WIDTH:0] RND_ONE = {{IN_WIDTH{1'b0}}, 1'b1};
    localparam logic [SHIFT_WIDTH-1:0]   SHIFT_ONE = {{(SHIFT_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [15:0]            len_q, len_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic                   z_valid_q, z_valid_d;
    logic [OUT_WIDTH-1:0]   z_data_q, z_data_d;

    logic                   accept;
    logic                   start_ok;
    logic                   sat;
    logic [OUT_WIDTH-1:0]   requant;

    logic signed [IN_WIDTH:0] y_ext;
    logic signed [IN_WIDTH:0] rnd;
    logic signed [IN_WIDTH:0] sum;
    logic signed [IN_WIDTH:0] shifted;

    // -------------------------------------------------------------------------
    // Arithmetic: one extra bit of headroom keeps the rounding add from
    // overflowing even for the most positive input and the largest shift.
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        y_ext = {y_data_i[IN_WIDTH-1], y_data_i};
        rnd   = '0;
        if (shift_q != '0) begin
            rnd = RND_ONE << (shift_q - SHIFT_ONE);
        end
        sum     = y_ext + rnd;
        shifted = sum >>> shift_q;

        sat     = 1'b0;
        requant = shifted[OUT_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            sat     = 1'b1;
            requant = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat     = 1'b1;
            requant = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

    // -------------------------------------------------------------------------
    // Handshake. Ready looks through to z_ready_i so a draining output
    // register can be refilled in the same cycle (full throughput).
    // -------------------------------------------------------------------------
    assign y_ready_o = (state_q == RUN) && (cnt_q < len_q) && (!z_valid_q || z_ready_i);
    assign accept    = y_valid_i && y_ready_o;
    assign start_ok  = (state_q == IDLE) && start_i;

    // -------------------------------------------------------------------------
    // Next-state logic: FSM, beat counter and output register.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        z_valid_d = z_valid_q;
        z_data_d  = z_data_q;

        if (accept) begin
            z_data_d  = requant;
            z_valid_d = 1'b1;
            cnt_d     = cnt_q + 16'd1;
        end else if (z_ready_i) begin
            z_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d   = len_i;
                    shift_d = shift_i;
                    cnt_d   = '0;
                    state_d = (len_i == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                // With all beats counted nothing more is accepted, so
                // z_valid_d low means the last beat drains at this edge and
                // done_o follows directly in the next cycle.
                if ((cnt_q == len_q) && !z_valid_d) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Soft clear wins over everything, discarding any pending beat.
        if (clear_i) begin
            state_d   = IDLE;
            len_d     = '0;
            shift_d   = '0;
            cnt_d     = '0;
            z_valid_d = 1'b0;
            z_data_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            len_q     <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            z_valid_q <= 1'b0;
            z_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            z_valid_q <= z_valid_d;
            z_data_q  <= z_data_d;
        end
    end

    assign z_valid_o = z_valid_q;
    assign z_data_o  = z_data_q;
    assign z_strb_o  = '1;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);

    // Byte strobes carry no meaning for accumulator samples.
    logic unused_strb;
    assign unused_strb = ^y_strb_i;

`ifdef FIR_REQUANT_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (clear_i || start_ok) begin
            sat_cnt_d = '0;
        end else if (accept && sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt_o = sat_cnt_q;
`else
    logic unused_sat;
    assign unused_sat = sat | start_ok;
`endif

endmodule
